msk_gf4_mul_hpc3_pipe: RTL and testbench

- Masked multi-lane GF(4) multiplier using the HPC3 scheme, d shares, 1-cycle gadget latency.
- Wraps the gadget in a valid/ready pipeline stage. Stalls hold state and stop randomness consumption.
- Generates the one-cycle-delayed a sharing internally, so callers no longer supply a separate prev input.
- Adds a per-transfer mode that scales the product by omega, as needed by masked GF(16)/GF(256) inversion datapaths.

---
 rtl/msk_gf4_mul_hpc3_pipe_pkg.sv | 34 +++
 rtl/msk_gf4_mul_hpc3_pipe_if.sv | 28 ++
 rtl/msk_gf4_mul_hpc3_pipe_lane.sv | 92 +++++++++
 rtl/msk_gf4_mul_hpc3_pipe.sv | 44 ++++
 tb/tb_msk_gf4_mul_hpc3_pipe.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/msk_gf4_mul_hpc3_pipe_pkg.sv
// GF(4) arithmetic and HPC3 randomness-indexing helpers shared by the masked multiplier.
// Latency: n/a (functions only).
// Backpressure: n/a.
// Contents: gf4_mul, gf4_omega, hpc3_rnd_bits, hpc3_pair_idx.
package msk_gf4_pkg;

  // Polynomial basis {1,w}, w^2 = w + 1; bit0 is the coefficient of 1.
  function automatic logic [1:0] gf4_mul(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] z;
    z[0] = (x[0] & y[0]) ^ (x[1] & y[1]);
    z[1] = (x[0] & y[1]) ^ (x[1] & y[0]) ^ (x[1] & y[1]);
    return z;
  endfunction

  // Multiplication by w: (x1,x0) -> (x1^x0, x1).
  function automatic logic [1:0] gf4_omega(input logic [1:0] x);
    return {x[1] ^ x[0], x[1]};
  endfunction

  // Two halves (r0, r1), each d(d-1) bits = d(d-1)/2 pairs of 2 bits.
  function automatic int hpc3_rnd_bits(input int d);
    return 2 * d * (d - 1);
  endfunction

  // Index of unordered share pair {i,j}, i != j; symmetric so r_ij = r_ji.
  function automatic int hpc3_pair_idx(input int i, input int j, input int d);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * d - (lo * (lo + 1)) / 2 + (hi - 1 - lo);
  endfunction

endpackage

// File: rtl/msk_gf4_mul_hpc3_pipe_if.sv
// Valid/ready bus of the masked GF(4) multiplier stage (operands, randomness, result).
// Latency: n/a (wiring only).
// Backpressure: in_ready is driven by the stage; out_ready by the consumer.
// Ports: in_valid/in_ready/in_mode/in_a/in_b/rnd upstream, out_valid/out_ready/out_z downstream.
interface msk_gf4_mul_hpc3_pipe_if #(
  parameter int d = 2,
  parameter int L = 1
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_mode;
  logic [2*L*d-1:0]         in_a;
  logic [2*L*d-1:0]         in_b;
  logic [L*2*d*(d-1)-1:0]   rnd;
  logic                     out_valid;
  logic                     out_ready;
  logic [2*L*d-1:0]         out_z;

  modport master (
    output in_valid, in_mode, in_a, in_b, rnd, out_ready,
    input  in_ready, out_valid, out_z
  );

  modport slave (
    input  in_valid, in_mode, in_a, in_b, rnd, out_ready,
    output in_ready, out_valid, out_z
  );
endinterface

// File: rtl/msk_gf4_mul_hpc3_pipe_lane.sv
// One masked GF(4) lane: HPC3 gadget with d shares, optional omega pre-scale of a, internal a_prev.
// Latency: 1 cycle from i_en to o_z.
// Backpressure: every register loads only when i_en=1, otherwise holds; o_z is purely registered.
// Ports: clk, rst_n, i_en (load), i_mode (omega scale), i_a/i_b (bit k*d+s), i_rnd (r0|r1), o_z.
module msk_gf4_mul_hpc3_lane
  import msk_gf4_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  input  logic                   i_mode,
  input  logic [2*d-1:0]         i_a,
  input  logic [2*d-1:0]         i_b,
  input  logic [2*d*(d-1)-1:0]   i_rnd,
  output logic [2*d-1:0]         o_z
);
  localparam int NH = d * (d - 1);  // offset of r1 inside the lane slice

  logic [1:0] w_a       [d];
  logic [1:0] w_b       [d];
  logic [1:0] w_u_nxt   [d][d];
  logic [1:0] w_bpr_nxt [d][d];
  logic [1:0] w_acc     [d];
  logic [1:0] r_aprev   [d];
  logic [1:0] r_u       [d][d];
  logic [1:0] r_bpr     [d][d];

  // Unpack shares; omega scaling is linear so it is applied share-wise.
  always_comb begin
    for (int i = 0; i < d; i++) begin
      w_a[i] = {i_a[d+i], i_a[i]};
      if (i_mode) w_a[i] = gf4_omega(w_a[i]);
      w_b[i] = {i_b[d+i], i_b[i]};
    end
  end

  // Diagonal entries are unused and stay zero.
  always_comb begin
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        w_u_nxt[i][j]   = '0;
        w_bpr_nxt[i][j] = '0;
        if (j != i) begin
          w_bpr_nxt[i][j] = w_b[j] ^ i_rnd[2*hpc3_pair_idx(i, j, d) +: 2];
          // The first off-diagonal j of each row (j2 == 0) also carries the a_i*b_i term.
          if ((j == 0) || (i == 0 && j == 1))
            w_u_nxt[i][j] = gf4_mul(w_a[i], w_b[i] ^ i_rnd[2*hpc3_pair_idx(i, j, d) +: 2])
                            ^ i_rnd[NH + 2*hpc3_pair_idx(i, j, d) +: 2];
          else
            w_u_nxt[i][j] = gf4_mul(w_a[i], i_rnd[2*hpc3_pair_idx(i, j, d) +: 2])
                            ^ i_rnd[NH + 2*hpc3_pair_idx(i, j, d) +: 2];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < d; i++) begin
        r_aprev[i] <= '0;
        for (int j = 0; j < d; j++) begin
          r_u[i][j]   <= '0;
          r_bpr[i][j] <= '0;
        end
      end
    end else if (i_en) begin
      for (int i = 0; i < d; i++) begin
        r_aprev[i] <= w_a[i];
        for (int j = 0; j < d; j++) begin
          r_u[i][j]   <= w_u_nxt[i][j];
          r_bpr[i][j] <= w_bpr_nxt[i][j];
        end
      end
    end
  end

  // Output compression uses registers only: no path from inputs to o_z.
  always_comb begin
    o_z = '0;
    for (int i = 0; i < d; i++) begin
      w_acc[i] = '0;
      for (int j = 0; j < d; j++) begin
        if (j != i) w_acc[i] = w_acc[i] ^ r_u[i][j] ^ gf4_mul(r_aprev[i], r_bpr[i][j]);
      end
      o_z[i]   = w_acc[i][0];
      o_z[d+i] = w_acc[i][1];
    end
  end

endmodule

// File: rtl/msk_gf4_mul_hpc3_pipe.sv
// Masked multi-lane GF(4) multiplier (HPC3, d shares) in a valid/ready pipeline stage, optional omega scale.
// Latency: 1 cycle from fire to out_valid/out_z; 1 transfer/cycle while out_ready=1.
// Backpressure: in_ready = ~out_valid | out_ready; stalled stage holds all shares and ignores rnd.
// Ports: clk, rst_n (async active-low), bus (slave modport: in_* / rnd / out_*).
module msk_gf4_mul_hpc3_pipe
  import msk_gf4_pkg::*;
#(
  parameter int d = 2,
  parameter int L = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  msk_gf4_mul_hpc3_pipe_if.slave      bus
);
  localparam int RB = hpc3_rnd_bits(d);

  logic r_out_valid;
  logic w_fire;

  assign bus.in_ready  = ~r_out_valid | bus.out_ready;
  assign w_fire        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = r_out_valid;

  // A fire while the old result retires keeps out_valid high (replace in place).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_out_valid <= 1'b0;
    else if (w_fire)        r_out_valid <= 1'b1;
    else if (bus.out_ready) r_out_valid <= 1'b0;
  end

  for (genvar l = 0; l < L; l++) begin : g_lane
    msk_gf4_mul_hpc3_lane #(.d(d)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_fire),
      .i_mode (bus.in_mode),
      .i_a    (bus.in_a[l*2*d +: 2*d]),
      .i_b    (bus.in_b[l*2*d +: 2*d]),
      .i_rnd  (bus.rnd[l*RB +: RB]),
      .o_z    (bus.out_z[l*2*d +: 2*d])
    );
  end

endmodule

// File: tb/tb_msk_gf4_mul_hpc3_pipe.sv
// Scoreboard bench: two DUT configurations (d=3,L=4 and d=2,L=1) against a log/antilog GF(4) model.
module tb_msk_gf4_mul_hpc3_pipe;
  localparam int D1 = 3, L1 = 4, W1 = 2*L1*D1, R1 = L1*2*D1*(D1-1);
  localparam int D2 = 2, L2 = 1, W2 = 2*L2*D2, R2 = L2*2*D2*(D2-1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  msk_gf4_mul_hpc3_pipe_if #(.d(D1), .L(L1)) bus1();
  msk_gf4_mul_hpc3_pipe_if #(.d(D2), .L(L2)) bus2();

  msk_gf4_mul_hpc3_pipe #(.d(D1), .L(L1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  msk_gf4_mul_hpc3_pipe #(.d(D2), .L(L2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int checks = 0;
  int failures = 0;
  int pops1 = 0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] m1_exp, m2_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---- reference model: GF(4)* is cyclic of order 3 generated by w ----
  function automatic int glog(input logic [1:0] x);
    case (x)
      2'd1:    return 0;
      2'd2:    return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] gexp(input int n);
    case (n % 3)
      0:       return 2'd1;
      1:       return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] gmul(input logic [1:0] x, input logic [1:0] y);
    if (x == 2'd0 || y == 2'd0) return 2'd0;
    return gexp(glog(x) + glog(y));
  endfunction

  function automatic logic [7:0] ref_vec(input logic [7:0] av, input logic [7:0] bv,
                                         input bit m, input int ll);
    logic [7:0] r = '0;
    logic [1:0] a;
    for (int l = 0; l < ll; l++) begin
      a = av[2*l +: 2];
      if (m) a = gmul(2'd2, a);
      r[2*l +: 2] = gmul(a, bv[2*l +: 2]);
    end
    return r;
  endfunction

  function automatic logic [63:0] share(input logic [7:0] val, input int dd, input int ll);
    logic [63:0] r = '0;
    logic acc;
    logic b;
    for (int l = 0; l < ll; l++)
      for (int k = 0; k < 2; k++) begin
        acc = val[l*2+k];
        for (int s = 0; s < dd-1; s++) begin
          b = 1'($urandom);
          r[(l*2+k)*dd+s] = b;
          acc ^= b;
        end
        r[(l*2+k)*dd+dd-1] = acc;
      end
    return r;
  endfunction

  function automatic logic [7:0] recomb(input logic [63:0] z, input int dd, input int ll);
    logic [7:0] r = '0;
    for (int l = 0; l < ll; l++)
      for (int k = 0; k < 2; k++)
        for (int s = 0; s < dd; s++)
          r[l*2+k] ^= z[(l*2+k)*dd+s];
    return r;
  endfunction

  // ---- monitors: pop and compare whenever a result is handed downstream ----
  always @(negedge clk) begin
    if (rst_n && bus1.out_valid && bus1.out_ready) begin
      if (q1.size() == 0) chk("sb1_unexpected_output", 1, 0);
      else begin
        m1_exp = q1.pop_front();
        chk("sb1_z", recomb(64'(bus1.out_z), D1, L1), m1_exp);
      end
      pops1++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus2.out_valid && bus2.out_ready) begin
      if (q2.size() == 0) chk("sb2_unexpected_output", 1, 0);
      else begin
        m2_exp = q2.pop_front();
        chk("sb2_z", recomb(64'(bus2.out_z), D2, L2), m2_exp);
      end
    end
  end

  // ---- drivers: one cycle each, inputs changed at posedge+1, fire sampled at negedge ----
  task automatic cyc1(input bit v, input bit m, input logic [W1-1:0] ash, input logic [W1-1:0] bsh,
                      input logic [R1-1:0] r, input logic [7:0] ex);
    bus1.in_valid = v; bus1.in_mode = m; bus1.in_a = ash; bus1.in_b = bsh; bus1.rnd = r;
    @(negedge clk);
    if (v && bus1.in_ready) q1.push_back(ex);
    @(posedge clk); #1;
  endtask

  task automatic go1(input bit v, input bit m, input logic [7:0] av, input logic [7:0] bv);
    logic [63:0] ash, bsh, r;
    ash = share(av, D1, L1);
    bsh = share(bv, D1, L1);
    r = {$urandom, $urandom};
    cyc1(v, m, ash[W1-1:0], bsh[W1-1:0], r[R1-1:0], ref_vec(av, bv, m, L1));
  endtask

  task automatic go2(input bit v, input bit m, input logic [1:0] a, input logic [1:0] b);
    logic [63:0] ash, bsh;
    logic [31:0] r;
    ash = share({6'd0, a}, D2, L2);
    bsh = share({6'd0, b}, D2, L2);
    r = $urandom;
    bus2.in_valid = v; bus2.in_mode = m; bus2.in_a = ash[W2-1:0]; bus2.in_b = bsh[W2-1:0];
    bus2.rnd = r[R2-1:0];
    @(negedge clk);
    if (v && bus2.in_ready) q2.push_back(ref_vec({6'd0, a}, {6'd0, b}, m, L2));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  logic [W1-1:0] zh, za, zb, ash1, bsh1;
  logic [R1-1:0] rr;
  logic [63:0] tmp;
  logic [7:0] av, bv, yv, ybv;
  logic [1:0] va[3] = '{2'd2, 2'd2, 2'd1};
  logic [1:0] vb[3] = '{2'd3, 2'd3, 2'd1};
  bit         vm[3] = '{1'b0, 1'b1, 1'b1};
  int p0;

  initial begin
    bus1.in_valid = 0; bus1.in_mode = 0; bus1.in_a = '0; bus1.in_b = '0; bus1.rnd = '0;
    bus1.out_ready = 1;
    bus2.in_valid = 0; bus2.in_mode = 0; bus2.in_a = '0; bus2.in_b = '0; bus2.rnd = '0;
    bus2.out_ready = 1;
    #1;
    chk("reset_out_valid_1", 64'(bus1.out_valid), 0);
    chk("reset_out_z_1", 64'(bus1.out_z), 0);
    chk("reset_out_valid_2", 64'(bus2.out_valid), 0);
    chk("reset_out_z_2", 64'(bus2.out_z), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    // d=2, L=1 directed vectors then random ones, one per cycle.
    for (int t = 0; t < 15; t++) begin
      if (t < 3) go2(1, vm[t], va[t], vb[t]);
      else       go2(1, 1'($urandom), 2'($urandom), 2'($urandom));
      chk("d2_out_valid", 64'(bus2.out_valid), 1);
    end
    go2(0, 0, 0, 0);
    chk("d2_drained", 64'(bus2.out_valid), 0);

    // Exhaustive (a,b,mode) on every lane, back to back.
    p0 = pops1;
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++) begin
          for (int l = 0; l < L1; l++) begin
            av[2*l +: 2] = 2'((a + l) % 4);
            bv[2*l +: 2] = 2'((b + 3*l) % 4);
          end
          go1(1, 1'(m), av, bv);
          chk("b2b_in_ready", 64'(bus1.in_ready), 1);
          chk("b2b_out_valid", 64'(bus1.out_valid), 1);
        end
    go1(0, 0, 8'd0, 8'd0);
    chk("b2b_result_count", 64'(pops1 - p0), 32);

    // Stall: hold a result five cycles while new operands and rnd churn on the input.
    bus1.out_ready = 0;
    go1(1, 1, 8'($urandom), 8'($urandom));
    zh = bus1.out_z;
    yv = 8'($urandom); ybv = 8'($urandom);
    for (int t = 0; t < 5; t++) begin
      go1(1, 0, yv, ybv);
      chk("stall_in_ready", 64'(bus1.in_ready), 0);
      chk("stall_out_z_held", 64'(bus1.out_z), 64'(zh));
      chk("stall_out_valid", 64'(bus1.out_valid), 1);
    end
    bus1.out_ready = 1;
    go1(1, 0, yv, ybv);
    chk("stall_next_valid", 64'(bus1.out_valid), 1);
    go1(0, 0, 8'd0, 8'd0);

    // Randomness sensitivity: only r1 of pair (0,1), lane 0 differs.
    av = 8'($urandom); bv = 8'($urandom);
    tmp = share(av, D1, L1); ash1 = tmp[W1-1:0];
    tmp = share(bv, D1, L1); bsh1 = tmp[W1-1:0];
    tmp = {$urandom, $urandom}; rr = tmp[R1-1:0];
    cyc1(1, 0, ash1, bsh1, rr, ref_vec(av, bv, 0, L1));
    za = bus1.out_z;
    cyc1(1, 0, ash1, bsh1, rr ^ (R1'(1) << (D1*(D1-1))), ref_vec(av, bv, 0, L1));
    zb = bus1.out_z;
    chk("rnd_shares_differ", 64'(za != zb), 1);
    for (int t = 0; t < 3; t++) begin
      go1(0, 0, 8'($urandom), 8'($urandom));
      chk("idle_rnd_out_z_held", 64'(bus1.out_z), 64'(zb));
    end

    // Asynchronous reset in the middle of a stall.
    bus1.out_ready = 0;
    go1(1, 1, 8'($urandom), 8'($urandom));
    go1(1, 0, 8'($urandom), 8'($urandom));
    chk("pre_reset_valid", 64'(bus1.out_valid), 1);
    bus1.in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("async_reset_out_valid", 64'(bus1.out_valid), 0);
    chk("async_reset_out_z", 64'(bus1.out_z), 0);
    q1.delete();
    @(negedge clk) rst_n = 1;
    bus1.out_ready = 1;
    @(posedge clk); #1;
    for (int t = 0; t < 3; t++) begin
      go1(0, 0, 8'd0, 8'd0);
      chk("post_reset_no_valid", 64'(bus1.out_valid), 0);
    end

    chk("sb1_empty", 64'(q1.size()), 0);
    chk("sb2_empty", 64'(q2.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
